// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write-side packet
//               arbiter: FSM state encoding and channel-header field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Channel header layout: [7:4] tag, [3:0] requester index, rest zero
    localparam int c_HDR_TAG_LSB = 4;
    localparam int c_HDR_TAG_W   = 4;
    localparam int c_HDR_IDX_LSB = 0;
    localparam int c_HDR_IDX_W   = 4;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches upward from
//               last_grant+1 (wrapping modulo NREQ) for the first set request.
// Ports       : req        - request vector
//               last_grant - index of the previously served requester
//               grant      - one-hot pick (zero when no request)
//               grant_idx  - binary index of the pick
//               any_req    - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_req
);

    int          w_sum;
    logic [IW-1:0] w_idx;

    // Offsets 1..NREQ from last_grant cover every requester exactly once,
    // with last_grant itself checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_sum = int'(last_grant) + i;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_idx = IW'(w_sum);
            if (!any_req && req[w_idx]) begin
                any_req       = 1'b1;
                grant[w_idx]  = 1'b1;
                grant_idx     = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares the FIFO write port among NREQ write-domain requesters.
//               Grants whole packets round-robin, prefixes each packet with a
//               one-word channel header and throttles on full / almost-full.
// Ports       : wclk, wrst_n      - write clock, async active-low reset
//               req_valid_i/data/last, req_ready_o - per-requester handshake
//               grant_o           - one-hot port owner (zero when idle)
//               fifo_wr_en_o/data - FIFO write port
//               fifo_full_i, fifo_awfull_i - FIFO flow-control flags
//               busy_o            - FSM not idle
//               pkt_cnt_o         - completed packet count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int         NREQ    = 4,
    parameter int         DSIZE   = 8,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*DSIZE-1:0] req_data_i,
    input  logic [NREQ-1:0]       req_last_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [NREQ-1:0]       grant_o,
    output logic                  fifo_wr_en_o,
    output logic [DSIZE-1:0]      fifo_wr_data_o,
    input  logic                  fifo_full_i,
    input  logic                  fifo_awfull_i,
    output logic                  busy_o,
    output logic [15:0]           pkt_cnt_o
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_grant_idx;
    logic [IW-1:0]   r_last_grant;
    logic [15:0]     r_pkt_cnt;
    logic            r_busy;

    logic [NREQ-1:0]  w_arb_grant;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_any;
    logic             w_gvalid;
    logic             w_glast;
    logic [DSIZE-1:0] w_gdata;
    logic [DSIZE-1:0] w_hdr;
    logic             w_hdr_wr;
    logic             w_beat_wr;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req        (req_valid_i),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant),
        .grant_idx  (w_arb_idx),
        .any_req    (w_arb_any)
    );

    // Granted requester's lane; r_grant is one-hot or zero.
    assign w_gvalid = |(req_valid_i & r_grant);
    assign w_glast  = |(req_last_i  & r_grant);

    always_comb begin
        w_gdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_gdata = req_data_i[k*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        w_hdr = '0;
        w_hdr[c_HDR_TAG_LSB +: c_HDR_TAG_W] = HDR_TAG;
        w_hdr[c_HDR_IDX_LSB +: c_HDR_IDX_W] = 4'(r_grant_idx);
    end

    // Header needs room for itself plus one beat, hence the almost-full gate.
    assign w_hdr_wr  = (r_state == ST_HDR) && !fifo_full_i && !fifo_awfull_i;
    assign w_beat_wr = (r_state == ST_DATA) && w_gvalid && !fifo_full_i;

    assign req_ready_o    = ((r_state == ST_DATA) && !fifo_full_i) ? r_grant : '0;
    assign fifo_wr_en_o   = w_hdr_wr | w_beat_wr;
    assign fifo_wr_data_o = w_hdr_wr  ? w_hdr   :
                            w_beat_wr ? w_gdata : '0;

    assign grant_o   = r_grant;
    assign busy_o    = r_busy;
    assign pkt_cnt_o = r_pkt_cnt;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= IW'(NREQ - 1);
            r_pkt_cnt    <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_grant     <= w_arb_grant;
                        r_grant_idx <= w_arb_idx;
                        r_busy      <= 1'b1;
                        r_state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_hdr_wr) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_wr && w_glast) begin
                        r_last_grant <= r_grant_idx;
                        r_pkt_cnt    <= r_pkt_cnt + 16'd1;
                        r_grant      <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fifo_wr_arbiter
`default_nettype wire
